rca_seq_ctrl: RTL and testbench
===============================

// Module: rca_seq_ctrl
// PURPOSE
//  Multi-cycle adder controller: adds two WIDTH-bit operands by sequencing one
//  2-bit ripple-carry slice over the operands, least-significant pair first.
//  Carry is registered between cycles. Operands arrive on a valid/ready input
//  handshake; the result leaves on a valid/ready output handshake.
//  Sits between an operand source (register file / test harness) and a result consumer.
// PARAMETERS
//  WIDTH   8   operand width in bits; must be even and >= 2 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      controller can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      initial carry-in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered sum
//  cout       out  1      registered final carry-out
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, sum=0, cout=0, out_valid=0, carry reg=0,
//    slice counter=0. rst mid-RUN/DONE aborts the operation; the result is discarded.
//  - States: IDLE, RUN, DONE. Outputs decoded from state: in_ready=(IDLE),
//    out_valid=(DONE), busy=(RUN|DONE).
//  - IDLE: on in_valid&&in_ready latch a,b; carry<=cin; cnt<=0; sum<=0; -> RUN.
//  - RUN: each cycle, slice idx=cnt: {c,s}=a[2i+1:2i]+b[2i+1:2i]+carry;
//    sum[2i+1:2i]<=s; carry<=c; cnt<=cnt+1. When cnt==WIDTH/2-1: cout<=c; -> DONE.
//  - DONE: sum/cout held stable while out_ready=0. On out_ready: -> IDLE.
//    sum/cout keep their value in IDLE until the next acceptance clears sum.
//  - Latency: accept at edge T; out_valid high after edge T+WIDTH/2.
//    Minimum initiation interval is WIDTH/2+2 cycles (no overlap of DONE and accept).
//  - in_valid while busy: ignored (in_ready=0); the source must hold it.
//  - Arithmetic: unsigned, modulo 2^WIDTH in sum; cout = bit WIDTH of a+b+cin.
//  - Counter width $clog2(WIDTH/2) (min 1); wraps only via state change, never in RUN.
// STRUCTURE
//  - Package rca_ctrl_pkg: enum logic [1:0] state_t {IDLE, RUN, DONE}; SLICE_W=2.
//  - Sub-module add_slice2: combinational 2-bit adder built from two full_add
//    cells with an explicit cin port (a[1:0], b[1:0], cin -> s[1:0], cout).
//    One instance, operand pair muxed by cnt.
// TESTING (WIDTH=8 unless noted)
//  1 a=8'hFF,b=8'h01,cin=0, out_ready=1 -> out_valid 4 cycles after accept,
//    sum=8'h00, cout=1; in_ready low until the cycle after the out handshake.
//  2 a=8'hA5,b=8'h5A,cin=1 -> sum=8'h00,cout=1; a=8'h12,b=8'h34,cin=0 -> 8'h46,0.
//  3 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable;
//    out_ready=1 -> IDLE next cycle, in_ready=1.
//  4 in_valid held high with new operands during RUN -> ignored; accepted only
//    in IDLE; second result correct and independent of the first.
//  5 rst=1 at 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0, cout=0;
//    the following operation completes correctly.
//  6 WIDTH=4 exhaustive: all a,b,cin (512 cases) vs reference a+b+cin, latency 2.

Source files
------------

// File: rtl/rca_ctrl_pkg.sv
// Shared types and constants for the sequential ripple-carry adder controller.
package rca_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int SLICE_W = 2;
endpackage

// File: rtl/add_slice2.sv
// Combinational 2-bit ripple-carry slice built from two full-adder cells.
module add_slice2
   import rca_ctrl_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);
   logic c0;

   full_add u_fa0 (.a(a[0]), .b(b[0]), .cin(cin), .s(s[0]), .cout(c0));
   full_add u_fa1 (.a(a[1]), .b(b[1]), .cin(c0),  .s(s[1]), .cout(cout));
endmodule

// File: rtl/full_add.sv
// One-bit full adder cell.
module full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: one 2-bit slice per cycle, LSB pair first, carry registered
// between cycles, valid/ready handshakes on operands and result.
module rca_seq_ctrl
   import rca_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int NSL   = WIDTH / SLICE_W;
   localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSL - 1);

   if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("rca_seq_ctrl: WIDTH must be even and >= 2");
   end

   state_t             state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt;
   logic [SLICE_W-1:0] sa;
   logic [SLICE_W-1:0] sb;
   logic [SLICE_W-1:0] ss;
   logic               sc;

   // The single slice walks the latched operands, selected by the slice counter.
   assign sa = a_q[{cnt, 1'b0} +: SLICE_W];
   assign sb = b_q[{cnt, 1'b0} +: SLICE_W];

   add_slice2 u_slice (.a(sa), .b(sb), .cin(carry_q), .s(ss), .cout(sc));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sum       <= '0;
         cout      <= 1'b0;
         carry_q   <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= b;
                  carry_q  <= cin;
                  cnt      <= '0;
                  sum      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               sum[{cnt, 1'b0} +: SLICE_W] <= ss;
               carry_q <= sc;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  cout      <= sc;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: an 8-bit instance for directed cases and a
// 4-bit instance swept over every operand combination.
module tb_rca_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
   logic [7:0] a8, b8, sum8;
   logic       in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
   logic [3:0] a4, b4, sum4;

   logic [8:0] q8[$];
   logic [4:0] q4[$];
   logic [8:0] e8;
   logic [4:0] e4;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rca_seq_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .busy(busy8));

   rca_seq_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .busy(busy4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Results are popped at the negedge preceding the output handshake edge.
   always @(negedge clk) begin
      if (!rst && out_valid8 && out_ready8) begin
         chk("sb8_avail", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            chk("sum8", 32'(sum8), 32'(e8[7:0]));
            chk("cout8", 32'(cout8), 32'(e8[8]));
         end
      end
      if (!rst && out_valid4 && out_ready4) begin
         chk("sb4_avail", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            chk("sum4", 32'(sum4), 32'(e4[3:0]));
            chk("cout4", 32'(cout4), 32'(e4[4]));
         end
      end
   end

   task automatic push8(input logic [7:0] ta, input logic [7:0] tb, input logic tci);
      a8 = ta; b8 = tb; cin8 = tci; in_valid8 = 1'b1;
      q8.push_back(9'(ta) + 9'(tb) + 9'(tci));
   endtask

   // Leaves the caller at #1 after the acceptance edge.
   task automatic wait_accept8();
      int n = 0;
      while (!in_ready8 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("accept8_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_result8(input string tag);
      int cyc = 0;
      while (!out_valid8 && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      chk(tag, 32'(cyc), 32'd4);
   endtask

   task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                         input int bp);
      logic [7:0] s0;
      logic       c0;
      out_ready8 = (bp == 0);
      push8(ta, tb, tci);
      wait_accept8();
      in_valid8 = 1'b0;
      chk("busy_run", 32'(busy8), 32'd1);
      wait_result8("latency8");
      chk("in_ready_done", 32'(in_ready8), 32'd0);
      s0 = sum8; c0 = cout8;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(out_valid8), 32'd1);
         chk("bp_sum", 32'(sum8), 32'(s0));
         chk("bp_cout", 32'(cout8), 32'(c0));
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready8), 32'd1);
      chk("idle_out_valid", 32'(out_valid8), 32'd0);
      chk("idle_busy", 32'(busy8), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_in_ready", 32'(in_ready8), 32'd1);
      chk("rst_out_valid", 32'(out_valid8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_cout", 32'(cout8), 32'd0);

      do_op8(8'hFF, 8'h01, 1'b0, 0);
      do_op8(8'hA5, 8'h5A, 1'b1, 0);
      do_op8(8'h12, 8'h34, 1'b0, 0);
      do_op8(8'h3C, 8'h7E, 1'b1, 5);

      // Operands change while the first operation runs; only IDLE may accept.
      out_ready8 = 1'b1;
      push8(8'hC3, 8'h4D, 1'b1);
      wait_accept8();
      push8(8'h80, 8'h80, 1'b0);
      chk("run_in_ready", 32'(in_ready8), 32'd0);
      wait_result8("latency8_first");
      wait_accept8();
      in_valid8 = 1'b0;
      wait_result8("latency8_second");
      @(posedge clk); #1;
      chk("second_idle", 32'(in_ready8), 32'd1);

      // Reset during the second RUN cycle discards the operation.
      push8(8'h0F, 8'h03, 1'b0);
      wait_accept8();
      in_valid8 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q8.delete();
      chk("abort_in_ready", 32'(in_ready8), 32'd1);
      chk("abort_out_valid", 32'(out_valid8), 32'd0);
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_sum", 32'(sum8), 32'd0);
      chk("abort_cout", 32'(cout8), 32'd0);
      do_op8(8'h9C, 8'h77, 1'b1, 0);

      for (int i = 0; i < 512; i++) begin
         int n;
         int cyc;
         logic [8:0] v;
         v = 9'(i);
         a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; in_valid4 = 1'b1;
         q4.push_back(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
         n = 0;
         while (!in_ready4 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         if (n >= 20) chk("accept4_timeout", 32'(n), 32'd0);
         @(posedge clk); #1;
         in_valid4 = 1'b0;
         cyc = 0;
         while (!out_valid4 && cyc < 10) begin
            @(posedge clk); #1; cyc++;
         end
         chk("latency4", 32'(cyc), 32'd2);
      end
      @(posedge clk); #1;

      chk("sb8_left", 32'(q8.size()), 32'd0);
      chk("sb4_left", 32'(q4.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
